// File: rtl/wb_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_write_arbiter : MEM-priority writeback arbiter with EX result FIFO,  |
// | hazard flags and optional forwarding (macro WB_BYPASS_EN).               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module wb_write_arbiter #(
  parameter int BANK_WIDTH = 5,
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid,
  output logic                          ex_ready,
  input  logic [BANK_WIDTH-1:0]         ex_rd,
  input  logic [WIDTH-1:0]              ex_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [BANK_WIDTH-1:0]         mem_rd,
  input  logic [WIDTH-1:0]              mem_data,
  output logic                          we3,
  output logic [BANK_WIDTH-1:0]         wa3,
  output logic [WIDTH-1:0]              wd3,
  input  logic [BANK_WIDTH-1:0]         q_ra1,
  input  logic [BANK_WIDTH-1:0]         q_ra2,
  output logic                          busy1,
  output logic                          busy2,
  output logic [WIDTH-1:0]              byp_data1,
  output logic [WIDTH-1:0]              byp_data2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int c_AW    = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_AW + 1;

  logic [BANK_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
  logic [WIDTH-1:0]      r_fifo_data [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wptr;
  logic [c_AW-1:0]       r_rptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_we;
  logic [BANK_WIDTH-1:0] r_wa;
  logic [WIDTH-1:0]      r_wd;

  logic [FIFO_DEPTH-1:0] w_ent_vld;
  logic [FIFO_DEPTH-1:0] w_mem_hit;
  logic [FIFO_DEPTH-1:0] w_hit1;
  logic [FIFO_DEPTH-1:0] w_hit2;
  logic                  w_mem_wr;
  logic                  w_push;
  logic                  w_pop;

  // An entry is live when its distance from the head is below the occupancy.
  for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_ent
    logic [c_AW-1:0] w_age;
    assign w_age        = c_AW'(i) - r_rptr;
    assign w_ent_vld[i] = ({1'b0, w_age} < r_count);
    assign w_mem_hit[i] = w_ent_vld[i] && (r_fifo_rd[i] == mem_rd);
    assign w_hit1[i]    = w_ent_vld[i] && (r_fifo_rd[i] == q_ra1);
    assign w_hit2[i]    = w_ent_vld[i] && (r_fifo_rd[i] == q_ra2);
  end

  // A MEM write to a register still queued from EX must wait so older EX data lands first.
  assign ex_ready  = (r_count != c_CNT_W'(FIFO_DEPTH));
  assign mem_ready = !(mem_valid && (mem_rd != '0) && (|w_mem_hit));
  assign w_mem_wr  = mem_valid && mem_ready && (mem_rd != '0);
  assign w_push    = ex_valid && ex_ready && (ex_rd != '0);
  assign w_pop     = !w_mem_wr && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_mem_wr) begin
        r_we <= 1'b1;
        r_wa <= mem_rd;
        r_wd <= mem_data;
      end else if (w_pop) begin
        r_we   <= 1'b1;
        r_wa   <= r_fifo_rd[r_rptr];
        r_wd   <= r_fifo_data[r_rptr];
        r_rptr <= r_rptr + c_AW'(1);
      end else begin
        r_we <= 1'b0;
      end
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= ex_rd;
      r_fifo_data[r_wptr] <= ex_data;
    end
  end

  assign we3        = r_we;
  assign wa3        = r_wa;
  assign wd3        = r_wd;
  assign fifo_count = r_count;

  assign busy1 = (q_ra1 != '0) && ((|w_hit1) || (r_we && (r_wa == q_ra1)));
  assign busy2 = (q_ra2 != '0) && ((|w_hit2) || (r_we && (r_wa == q_ra2)));

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [c_AW-1:0] w_idx;
    byp_data1 = (r_we && (r_wa == q_ra1)) ? r_wd : '0;
    byp_data2 = (r_we && (r_wa == q_ra2)) ? r_wd : '0;
    w_idx     = r_rptr;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      w_idx = r_rptr + c_AW'(k);
      if (c_CNT_W'(k) < r_count) begin
        if (r_fifo_rd[w_idx] == q_ra1) byp_data1 = r_fifo_data[w_idx];
        if (r_fifo_rd[w_idx] == q_ra2) byp_data2 = r_fifo_data[w_idx];
      end
    end
  end
`else
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule
`default_nettype wire
